// File: rtl/hazard_ctrl.sv
// Pipeline hazard unit: load-use stall, control-hazard flush, operand forwarding,
// and a whole-pipe freeze for multi-cycle data-memory accesses with timeout.
module hazard_ctrl #(
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       Rs1E,
  input  logic [4:0]       Rs2E,
  input  logic [4:0]       RdE,
  input  logic [1:0]       ResultSrcE,
  input  logic             PCSrcE,
  input  logic [4:0]       RdM,
  input  logic             RegWriteM,
  input  logic             MemReqM,
  input  logic             MemReadyM,
  input  logic [4:0]       RdW,
  input  logic             RegWriteW,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             MemErr,
  output logic [CNT_W-1:0] LuStallCnt,
  output logic [CNT_W-1:0] FlushCnt,
  output logic [CNT_W-1:0] MemWaitCnt
);

  typedef enum logic [1:0] {S_RUN, S_WAIT, S_ERR} state_t;

  state_t           r_state;
  logic [15:0]      r_tmo;
  logic             r_err;
  logic [CNT_W-1:0] r_lu_cnt;
  logic [CNT_W-1:0] r_fl_cnt;
  logic [CNT_W-1:0] r_mw_cnt;

  logic w_lw_stall;
  logic w_mem_busy;
  logic w_not_err;

  assign w_lw_stall = (ResultSrcE == 2'b01) && (RdE != 5'd0) &&
                      ((RdE == Rs1D) || (RdE == Rs2D));
  assign w_mem_busy = MemReqM && !MemReadyM;
  assign w_not_err  = (r_state != S_ERR);

  function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
    if (RegWriteM && (RdM != 5'd0) && (RdM == rs))
      return 2'b10;
    else if (RegWriteW && (RdW != 5'd0) && (RdW == rs))
      return 2'b01;
    else
      return 2'b00;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    return (en && (v != '1)) ? v + CNT_W'(1) : v;
  endfunction

  // Stall/flush must react in the same cycle as memBusy, so they are combinational
  // from the registered state; everything is held at 0 while reset is asserted.
  always_comb begin
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    StallM    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    FlushW    = 1'b0;
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    if (rst) begin
      ForwardAE = fwd_sel(Rs1E);
      ForwardBE = fwd_sel(Rs2E);
      if (!w_not_err) begin
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        StallM = 1'b1;
      end else if (w_mem_busy) begin
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        StallM = 1'b1;
        FlushW = 1'b1;
      end else begin
        StallF = w_lw_stall;
        StallD = w_lw_stall;
        FlushD = PCSrcE;
        FlushE = w_lw_stall || PCSrcE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_RUN;
      r_tmo    <= '0;
      r_err    <= 1'b0;
      r_lu_cnt <= '0;
      r_fl_cnt <= '0;
      r_mw_cnt <= '0;
    end else begin
      case (r_state)
        S_RUN: begin
          if (w_mem_busy) begin
            r_state <= S_WAIT;
            r_tmo   <= 16'd1;
          end
        end
        S_WAIT: begin
          if (MemReadyM || !MemReqM) begin
            r_state <= S_RUN;
            r_tmo   <= '0;
          end else if (r_tmo == 16'(MEM_TIMEOUT)) begin
            r_state <= S_ERR;
            r_err   <= 1'b1;
          end else begin
            r_tmo <= r_tmo + 16'd1;
          end
        end
        default: r_state <= S_ERR;
      endcase
      r_lu_cnt <= sat_inc(r_lu_cnt, w_not_err && !w_mem_busy && w_lw_stall);
      r_fl_cnt <= sat_inc(r_fl_cnt, w_not_err && !w_mem_busy && PCSrcE);
      r_mw_cnt <= sat_inc(r_mw_cnt, w_not_err && w_mem_busy);
    end
  end

  assign MemErr     = r_err;
  assign LuStallCnt = r_lu_cnt;
  assign FlushCnt   = r_fl_cnt;
  assign MemWaitCnt = r_mw_cnt;

endmodule
